// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serialising memory arbiter.
package mem_ctrl_pkg;

  // RAM byte-address width; addresses wrap modulo 2**RAM_AW
  localparam int RAM_AW   = 17;
  // {mem_stall_req, if_stall_req}
  localparam int StallBus = 2;

  localparam logic [1:0] LenByte = 2'b00;
  localparam logic [1:0] LenHalf = 2'b01;
  localparam logic [1:0] LenWord = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  // Number of RAM byte cycles for an access length; the reserved code acts as a word
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LenByte: return 3'd1;
      LenHalf: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Single-port arbiter between fetch and MEM stage in front of a byte-wide RAM.
// Accesses are split into one-byte RAM cycles; reads assemble little-endian data.
//
// state    | meaning
// ST_IDLE  | no access in flight; data request wins over fetch
// ST_READ  | addressing byte cnt, capturing byte cnt-1 (RAM has one cycle latency)
// ST_WRITE | writing byte cnt of the latched store data
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic [RAM_AW-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i,
  output logic              if_stall_req_o,
  output logic              mem_stall_req_o
);

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [31:0]         base_q, base_d;
  logic [2:0]          len_q, len_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [31:0]         asm_q, asm_d;
  logic [31:0]         if_data_q, if_data_d;
  logic [31:0]         mem_rdata_q, mem_rdata_d;
  logic                if_done_q, if_done_d;
  logic                mem_done_q, mem_done_d;

  logic [31:0]         asm_byte;
  logic [1:0]          byte_idx;
  logic [31:0]         addr_full;
  logic                unused_addr_hi;
  logic [StallBus-1:0] stall_bus;

  // State and datapath registers; rdy low freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      base_q      <= '0;
      len_q       <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      asm_q       <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  // Read byte arriving now belongs to the byte addressed in the previous cycle
  always_comb begin
    byte_idx = cnt_q[1:0] - 2'd1;
    asm_byte = asm_q;
    asm_byte[{byte_idx, 3'b000} +: 8] = ram_din_i;
  end

  // Next-state, acceptance and completion logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    len_d       = len_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_i && !mem_done_q) begin
          owner_d = OWN_MEM;
          base_d  = mem_addr_i;
          len_d   = len_bytes(mem_len_i);
          wdata_d = mem_wdata_i;
          cnt_d   = '0;
          asm_d   = '0;
          state_d = mem_we_i ? ST_WRITE : ST_READ;
        end else if (if_req_i && !if_done_q) begin
          owner_d = OWN_IF;
          base_d  = if_addr_i;
          len_d   = 3'd4;
          cnt_d   = '0;
          asm_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (owner_q == OWN_IF && !if_req_i) begin
          // fetch withdrawn (e.g. redirect): drop it without a done pulse
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q != 3'd0) asm_d = asm_byte;
          if (cnt_q == len_q) begin
            state_d = ST_IDLE;
            if (owner_q == OWN_IF) begin
              if_done_d = 1'b1;
              if_data_d = asm_byte;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = asm_byte;
            end
          end
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == len_q - 3'd1) begin
          state_d    = ST_IDLE;
          mem_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM side: address wraps at the RAM size, write data only driven while writing
  always_comb begin
    addr_full      = base_q + {29'd0, cnt_q};
    ram_a_o        = addr_full[RAM_AW-1:0];
    unused_addr_hi = ^addr_full[31:RAM_AW];
    ram_wr_o       = (state_q == ST_WRITE) && rdy;
    ram_dout_o     = 8'h00;
    if (state_q == ST_WRITE) ram_dout_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
  end

  // Pipeline-facing outputs; a port stops stalling in its own done cycle
  always_comb begin
    stall_bus       = {mem_req_i & ~mem_done_q, if_req_i & ~if_done_q};
    mem_stall_req_o = stall_bus[1];
    if_stall_req_o  = stall_bus[0];
    if_data_o       = if_data_q;
    if_done_o       = if_done_q;
    mem_rdata_o     = mem_rdata_q;
    mem_done_o      = mem_done_q;
  end

endmodule
